// File: rtl/piso_sched_pkg.sv
// Shared definitions for the round-robin PISO scheduler.
//   state_e  : scheduler FSM states (ST_PARITY is only reachable when the
//              parity build option PISO_PARITY_EN is defined)
//   id_width : width of a requester index for a given requester count
package piso_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Width of an encoded requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts one position after ptr (wrapping) and grants the first
// asserted request. Nothing is granted while en is low.
//   req       in   N_REQ  request vector
//   ptr       in   IDW    index of the most recently granted requester
//   en        in   1      grant enable (accept slot open)
//   grant     out  N_REQ  one-hot grant (all zero if none)
//   grant_idx out  IDW    encoded index of the granted requester
//   grant_vld out  1      some requester is granted this cycle
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             grant_vld
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
        grant_vld = found;
    end

endmodule

// File: rtl/piso_rr_sched.sv
// Round-robin scheduler sharing one MSB-first parallel-to-serial shifter
// among N_REQ requesters. One word is accepted per valid/ready handshake and
// streamed out one bit per clock, tagged with the granted requester index.
//
// Handshake: requester k transfers a word on a rising edge where
// req_valid_i[k] && req_ready_o[k]. req_ready_o is combinational, at most one
// bit high, and only while the accept slot is open (idle, or the final
// serial bit of the current word). A requester holds valid/data stable until
// accepted; withdrawing valid before acceptance is allowed.
//
// Build option: define PISO_PARITY_EN to append an even-parity bit to each
// word (the parity bit carries ser_last_o and is the accept slot).
//
// Ports:
//   clk_in       in   1              clock, rising edge
//   rst          in   1              synchronous active-high reset
//   req_valid_i  in   N_REQ          per-requester word valid
//   req_data_i   in   N_REQ*WIDTH    words, requester k at [k*WIDTH +: WIDTH]
//   req_ready_o  out  N_REQ          one-hot accept
//   ser_data_o   out  1              serial bit, MSB first
//   ser_valid_o  out  1              ser_data_o is valid
//   ser_last_o   out  1              final bit of the current word
//   ser_id_o     out  $clog2(N_REQ)  requester index of the word being sent
//   busy_o       out  1              shifter occupied
module piso_rr_sched
    import piso_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*WIDTH-1:0]   req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     ser_data_o,
    output logic                     ser_valid_o,
    output logic                     ser_last_o,
    output logic [$clog2(N_REQ)-1:0] ser_id_o,
    output logic                     busy_o
);

    localparam int IDW = id_width(N_REQ);
    localparam int CW  = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             ser_data_q, ser_data_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_last_q, ser_last_d;
    logic [IDW-1:0]   ser_id_q, ser_id_d;
    logic             busy_q, busy_d;

    logic             slot_open;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic [WIDTH-1:0] word_sel;

    // The accept slot is the cycle whose bit ends the current word, so a new
    // word loads with no bubble.
    always_comb begin
`ifdef PISO_PARITY_EN
        slot_open = (state_q == ST_IDLE) || (state_q == ST_PARITY);
`else
        slot_open = (state_q == ST_IDLE) ||
                    ((state_q == ST_SHIFT) && (cnt_q == CW'(1)));
`endif
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req       (req_valid_i),
        .ptr       (ptr_q),
        .en        (slot_open),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (accept)
    );

    assign req_ready_o = grant;
    assign word_sel    = req_data_i[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        // The pointer moves only on an actual accept.
        ptr_d   = accept ? grant_idx : ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = word_sel;
                    cnt_d   = CW'(WIDTH);
                    id_d    = grant_idx;
`ifdef PISO_PARITY_EN
                    par_d   = ^word_sel;
`endif
                end
            end
            ST_SHIFT: begin
                shreg_d = shreg_q << 1;
                if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = '0;
`ifdef PISO_PARITY_EN
                    state_d = ST_PARITY;
`else
                    if (accept) begin
                        state_d = ST_SHIFT;
                        shreg_d = word_sel;
                        cnt_d   = CW'(WIDTH);
                        id_d    = grant_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = word_sel;
                    cnt_d   = CW'(WIDTH);
                    id_d    = grant_idx;
                    par_d   = ^word_sel;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers are decoded from the next state so every output lines
    // up with the internal registers on the same cycle.
    always_comb begin
        ser_valid_d = (state_d != ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        ser_id_d    = id_d;
        ser_data_d  = 1'b0;
        ser_last_d  = 1'b0;
        if (state_d == ST_SHIFT) begin
            ser_data_d = shreg_d[WIDTH-1];
`ifndef PISO_PARITY_EN
            ser_last_d = (cnt_d == CW'(1));
`endif
        end
`ifdef PISO_PARITY_EN
        if (state_d == ST_PARITY) begin
            ser_data_d = par_d;
            ser_last_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            ptr_q       <= IDW'(N_REQ - 1);
`ifdef PISO_PARITY_EN
            par_q       <= 1'b0;
`endif
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            ser_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
`ifdef PISO_PARITY_EN
            par_q       <= par_d;
`endif
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            ser_id_q    <= ser_id_d;
            busy_q      <= busy_d;
        end
    end

    assign ser_data_o  = ser_data_q;
    assign ser_valid_o = ser_valid_q;
    assign ser_last_o  = ser_last_q;
    assign ser_id_o    = ser_id_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_piso_rr_sched.sv
// Bench for piso_rr_sched: a stimulus table for a single word, directed
// multi-cycle sequences and randomized traffic, all checked every cycle
// against a reference model that holds the queue of serial bits still owed.
module tb_piso_rr_sched;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             ser_data, ser_valid, ser_last, busy;
    logic [IDW-1:0]   ser_id;

    piso_rr_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk_in      (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .ser_data_o  (ser_data),
        .ser_valid_o (ser_valid),
        .ser_last_o  (ser_last),
        .ser_id_o    (ser_id),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic           data;
        logic           last;
        logic [IDW-1:0] id;
    } bit_t;

    bit_t           pend[$];   // head = bit currently on the serial output
    int             m_ptr;
    logic [IDW-1:0] m_id;
    int             m_g;       // requester accepted at the coming edge, -1 none
    logic [W-1:0]   m_wd;
    logic [W-1:0]   words[N];

    int n_cmp, n_err;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int arb(input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic put_data();
        for (int k = 0; k < N; k++) req_data[k*W +: W] = words[k];
    endtask

    // Negedge: compare every output against the model, choose the grant.
    task automatic sample_check();
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        exp_rdy = '0;
        m_g     = -1;
        if (pend.size() <= 1) begin
            m_g = arb(req_valid);
            if (m_g >= 0) begin
                exp_rdy[m_g] = 1'b1;
                m_wd = req_data[m_g*W +: W];
            end
        end
        if (pend.size() > 0) m_id = pend[0].id;
        chk("ready", int'(req_ready), int'(exp_rdy));
        chk("ser_valid", int'(ser_valid), int'(pend.size() > 0));
        chk("ser_data", int'(ser_data), (pend.size() > 0) ? int'(pend[0].data) : 0);
        chk("ser_last", int'(ser_last), (pend.size() > 0) ? int'(pend[0].last) : 0);
        chk("ser_id", int'(ser_id), int'(m_id));
        chk("busy", int'(busy), int'(pend.size() > 0));
    endtask

    // Posedge: retire the current bit and enqueue the accepted word.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            pend.delete();
            m_ptr = N - 1;
            m_id  = '0;
            m_g   = -1;
        end else begin
            if (pend.size() > 0) void'(pend.pop_front());
            if (m_g >= 0) begin
                for (int b = W - 1; b >= 0; b--)
                    pend.push_back('{m_wd[b], (PAR == 0) && (b == 0), IDW'(m_g)});
                if (PAR != 0) pend.push_back('{^m_wd, 1'b1, IDW'(m_g)});
                m_ptr = m_g;
            end
        end
        #1;
    endtask

    task automatic cycle(output int g);
        put_data();
        sample_check();
        advance();
        g = m_g;
    endtask

    task automatic do_reset();
        int g;
        req_valid = '0;
        rst = 1'b1;
        cycle(g);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int exp_k, input string name);
        int g;
        for (int c = 0; c < 40; c++) begin
            cycle(g);
            if (g >= 0) begin
                chk(name, g, exp_k);
                req_valid[g] = 1'b0;
                return;
            end
        end
        chk({name, "_timeout"}, -1, exp_k);
    endtask

    task automatic drain();
        int g;
        for (int c = 0; c < 40 && pend.size() > 0; c++) cycle(g);
        chk("drain_idle", int'(pend.size() == 0), 1);
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [N-1:0]   vld;
        logic [W-1:0]   d0;
        logic [N-1:0]   rdy;
        logic           sv;
        logic           sd;
        logic           sl;
        logic [IDW-1:0] sid;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int           g, grants, last_cnt;
        int           order[$];
        logic [W-1:0] a5;
        vec_t         v;

        n_cmp = 0;
        n_err = 0;
        req_valid = '0;
        for (int k = 0; k < N; k++) words[k] = '0;
        put_data();

        // Single word 8'hA5 from requester 0 after reset.
        a5 = 8'hA5;
        tbl.push_back('{4'b0001, a5, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0});
        for (int i = 1; i <= W; i++)
            tbl.push_back('{4'b0000, a5, 4'b0000, 1'b1, a5[W-i],
                            (PAR == 0) && (i == W), 2'd0});
        if (PAR != 0) tbl.push_back('{4'b0000, a5, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0});
        tbl.push_back('{4'b0000, a5, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0});
        tbl.push_back('{4'b0000, a5, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0});

        // Reset with no model history: first check only after the reset edge.
        rst = 1'b1;
        @(posedge clk);
        #1;
        pend.delete();
        m_ptr = N - 1;
        m_id  = '0;
        do_reset();
        for (int c = 0; c < 3; c++) cycle(g);

        // Table-driven single word.
        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            req_valid = v.vld;
            words[0]  = v.d0;
            put_data();
            sample_check();
            chk($sformatf("tbl%0d_ready", r), int'(req_ready), int'(v.rdy));
            chk($sformatf("tbl%0d_valid", r), int'(ser_valid), int'(v.sv));
            chk($sformatf("tbl%0d_data", r), int'(ser_data), int'(v.sd));
            chk($sformatf("tbl%0d_last", r), int'(ser_last), int'(v.sl));
            chk($sformatf("tbl%0d_id", r), int'(ser_id), int'(v.sid));
            advance();
        end

        // Continuous contention: grant order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int k = 0; k < N; k++) words[k] = W'(k + 1);
        req_valid = '1;
        grants = 0;
        for (int c = 0; c < 200 && grants < 8; c++) begin
            cycle(g);
            if (g >= 0) begin
                order.push_back(g);
                grants++;
            end
        end
        chk("contention_grants", grants, 8);
        for (int i = 0; i < order.size(); i++)
            chk($sformatf("grant_order%0d", i), order[i], i % N);
        req_valid = '0;
        drain();

        // Pointer behaviour: 0, then 2 alone, then 0 and 3 together.
        do_reset();
        words[0] = 8'h3C;
        req_valid[0] = 1'b1;
        wait_grant(0, "ptr_first");
        words[2] = 8'h5A;
        req_valid[2] = 1'b1;
        wait_grant(2, "ptr_req2");
        words[0] = 8'hC3;
        words[3] = 8'h96;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        wait_grant(3, "ptr_req3_first");
        wait_grant(0, "ptr_req0_second");
        drain();

        // Valid withdrawn while busy: requester 1 is never granted.
        words[0] = 8'hF0;
        req_valid[0] = 1'b1;
        wait_grant(0, "drop_setup");
        words[1] = 8'h11;
        req_valid[1] = 1'b1;
        cycle(g);
        chk("drop_grant_now", g, -1);
        req_valid[1] = 1'b0;
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            cycle(g);
            if (g >= 0) grants++;
        end
        chk("drop_no_grant", grants, 0);

        // Reset mid-word: no further bits and no last marker.
        words[1] = 8'hFF;
        req_valid[1] = 1'b1;
        wait_grant(1, "rst_setup");
        for (int c = 0; c < 3; c++) cycle(g);
        do_reset();
        last_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(g);
            if (ser_last || ser_valid) last_cnt++;
        end
        chk("rst_no_bits", last_cnt, 0);

        // Back-to-back 8'hA5 then 8'h07 (parity bits 0 then 1 with parity on).
        words[0] = 8'hA5;
        words[1] = 8'h07;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        wait_grant(0, "par_first");
        wait_grant(1, "par_second");
        drain();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
                    words[k] = W'($urandom);
                    req_valid[k] = 1'b1;
                end else if (req_valid[k] && $urandom_range(0, 15) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 499) == 0);
            cycle(g);
            rst = 1'b0;
            if (g >= 0) req_valid[g] = 1'b0;
        end
        req_valid = '0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
